// File: rtl/tiny_fpga_cfg_ctrl.sv
// Configuration controller for a ROWS x COLS tile grid: loads the bitstream from an
// AXI-stream slave into the tile config shift chain and gates fabric run enable.
module tiny_fpga_cfg_ctrl #(
   parameter int ROWS                 = 2,
   parameter int COLS                 = 2,
   parameter int TILE_CFG_BITS        = 20,
   parameter int BITSTREAM_DATA_WIDTH = 1,
   parameter int TIMEOUT_CYCLES       = 1024
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            cfg_i,
   input  logic                            cfg_bitstream_tvalid_i,
   output logic                            cfg_bitstream_tready_o,
   input  logic [BITSTREAM_DATA_WIDTH-1:0] cfg_bitstream_tdata_i,
   input  logic                            cfg_bitstream_tlast_i,
   output logic                            cfg_ready_o,
   output logic                            cfg_error_o,
   output logic                            chain_shift_o,
   output logic [BITSTREAM_DATA_WIDTH-1:0] chain_data_o,
   input  logic                            run_i,
   output logic                            run_en_o
);

   localparam int TOTAL_BITS  = ROWS * COLS * TILE_CFG_BITS;
   localparam int TOTAL_BEATS = TOTAL_BITS / BITSTREAM_DATA_WIDTH;
   localparam int CNT_W       = $clog2(TOTAL_BEATS + 1);
   localparam int IDLE_W      = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(TOTAL_BEATS - 1);
   localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(TIMEOUT_CYCLES);

   generate
      if (TOTAL_BITS % BITSTREAM_DATA_WIDTH != 0) begin : g_width_check
         $error("grid config bits must be a multiple of BITSTREAM_DATA_WIDTH");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, LOAD, READY, ERROR} state_e;

   state_e                    state_q, state_d;
   logic [CNT_W-1:0]          beat_cnt_q, beat_cnt_d;
   logic [IDLE_W-1:0]         idle_cnt_q, idle_cnt_d;
   logic                      cfg_ready_q, cfg_ready_d;
   logic                      cfg_error_q, cfg_error_d;
   logic                      chain_shift_q, chain_shift_d;
   logic [BITSTREAM_DATA_WIDTH-1:0] chain_data_q, chain_data_d;
   logic                      run_en_q, run_en_d;
   logic                      tready;
   logic                      accept;

   // A restart request in the same cycle as a beat wins, so that beat is left stalled.
   assign tready = (state_q == LOAD) && !cfg_i;
   assign accept = cfg_bitstream_tvalid_i && tready;

   always_comb begin
      state_d       = state_q;
      beat_cnt_d    = beat_cnt_q;
      idle_cnt_d    = idle_cnt_q;
      cfg_ready_d   = cfg_ready_q;
      cfg_error_d   = cfg_error_q;
      chain_shift_d = 1'b0;
      chain_data_d  = chain_data_q;
      run_en_d      = run_i && cfg_ready_q && !cfg_i;

      if (cfg_i) begin
         state_d     = LOAD;
         beat_cnt_d  = '0;
         idle_cnt_d  = '0;
         cfg_ready_d = 1'b0;
         cfg_error_d = 1'b0;
      end else if (state_q == LOAD) begin
         if (accept) begin
            chain_shift_d = 1'b1;
            chain_data_d  = cfg_bitstream_tdata_i;
            beat_cnt_d    = beat_cnt_q + 1'b1;
            idle_cnt_d    = '0;
            if (beat_cnt_q == LAST_BEAT) begin
               if (cfg_bitstream_tlast_i) begin
                  state_d     = READY;
                  cfg_ready_d = 1'b1;
               end else begin
                  state_d     = ERROR;
                  cfg_error_d = 1'b1;
               end
            end else if (cfg_bitstream_tlast_i) begin
               state_d     = ERROR;
               cfg_error_d = 1'b1;
            end
         end else begin
            if (idle_cnt_q != IDLE_MAX) begin
               idle_cnt_d = idle_cnt_q + 1'b1;
            end
            // Watchdog fires on the cycle the idle count reaches its limit.
            if ((TIMEOUT_CYCLES != 0) && (idle_cnt_d == IDLE_MAX)) begin
               state_d     = ERROR;
               cfg_error_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         beat_cnt_q    <= '0;
         idle_cnt_q    <= '0;
         cfg_ready_q   <= 1'b0;
         cfg_error_q   <= 1'b0;
         chain_shift_q <= 1'b0;
         chain_data_q  <= '0;
         run_en_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         beat_cnt_q    <= beat_cnt_d;
         idle_cnt_q    <= idle_cnt_d;
         cfg_ready_q   <= cfg_ready_d;
         cfg_error_q   <= cfg_error_d;
         chain_shift_q <= chain_shift_d;
         chain_data_q  <= chain_data_d;
         run_en_q      <= run_en_d;
      end
   end

   assign cfg_bitstream_tready_o = tready;
   assign cfg_ready_o            = cfg_ready_q;
   assign cfg_error_o            = cfg_error_q;
   assign chain_shift_o          = chain_shift_q;
   assign chain_data_o           = chain_data_q;
   assign run_en_o               = run_en_q;

endmodule

// File: tb/tb_tiny_fpga_cfg_ctrl.sv
// Bench for tiny_fpga_cfg_ctrl: a 2x2/1-bit instance (short watchdog) and a 3x3/4-bit
// instance share stimulus; sel picks which one the checks observe.
module tb_tiny_fpga_cfg_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cfg = 1'b0;
   logic       tvalid = 1'b0;
   logic       tlast = 1'b0;
   logic       run = 1'b0;
   logic [3:0] tdata = 4'h0;

   logic       a_tready, a_ready, a_error, a_shift, a_run_en;
   logic [0:0] a_data;
   logic       b_tready, b_ready, b_error, b_shift, b_run_en;
   logic [3:0] b_data;

   logic       o_tready, o_ready, o_error, o_shift, o_run_en;
   logic [3:0] o_data;

   int sel = 0;
   int n_cmp = 0;
   int n_bad = 0;
   int shift_seen = 0;

   always #5 clk = ~clk;

   tiny_fpga_cfg_ctrl #(.TIMEOUT_CYCLES(16)) dut_a (
      .clk(clk), .rst_n(rst_n), .cfg_i(cfg),
      .cfg_bitstream_tvalid_i(tvalid), .cfg_bitstream_tready_o(a_tready),
      .cfg_bitstream_tdata_i(tdata[0:0]), .cfg_bitstream_tlast_i(tlast),
      .cfg_ready_o(a_ready), .cfg_error_o(a_error), .chain_shift_o(a_shift),
      .chain_data_o(a_data), .run_i(run), .run_en_o(a_run_en));

   tiny_fpga_cfg_ctrl #(.ROWS(3), .COLS(3), .BITSTREAM_DATA_WIDTH(4)) dut_b (
      .clk(clk), .rst_n(rst_n), .cfg_i(cfg),
      .cfg_bitstream_tvalid_i(tvalid), .cfg_bitstream_tready_o(b_tready),
      .cfg_bitstream_tdata_i(tdata), .cfg_bitstream_tlast_i(tlast),
      .cfg_ready_o(b_ready), .cfg_error_o(b_error), .chain_shift_o(b_shift),
      .chain_data_o(b_data), .run_i(run), .run_en_o(b_run_en));

   always_comb begin
      o_tready = (sel != 0) ? b_tready : a_tready;
      o_ready  = (sel != 0) ? b_ready  : a_ready;
      o_error  = (sel != 0) ? b_error  : a_error;
      o_shift  = (sel != 0) ? b_shift  : a_shift;
      o_run_en = (sel != 0) ? b_run_en : a_run_en;
      o_data   = (sel != 0) ? b_data   : {3'b000, a_data};
   end

   always @(negedge clk) if (o_shift) shift_seen++;

   // Reference model: grid size and beat width decide the beat total.
   function automatic int total_beats();
      return (sel != 0) ? (3 * 3 * 20) / 4 : (2 * 2 * 20) / 1;
   endfunction

   function automatic logic [3:0] data_mask();
      return (sel != 0) ? 4'hF : 4'h1;
   endfunction

   // A load succeeds only when the first tlast is on the final beat.
   function automatic bit stream_ok(input int total, input int tlast_at);
      return tlast_at == total - 1;
   endfunction

   function automatic int beats_accepted(input int total, input int tlast_at);
      return (tlast_at >= 0 && tlast_at < total) ? tlast_at + 1 : total;
   endfunction

   task automatic pulse_cfg();
      @(negedge clk); cfg = 1'b1;
      @(negedge clk); cfg = 1'b0;
      #1;
      n_cmp++;
      if (o_tready !== 1'b1) begin
         n_bad++; $display("FAIL cfg_tready: got %0b want 1", o_tready);
      end
   endtask

   task automatic send_stream(input int n, input int tlast_at, input int max_gap,
                              input bit check_end, input string tag);
      int start;
      int w;
      logic [3:0] exp_data;
      bit ok;
      start = shift_seen;
      for (int i = 0; i < n; i++) begin
         tvalid = 1'b0;
         repeat ($urandom_range(max_gap, 0)) @(negedge clk);
         tvalid = 1'b1;
         tdata  = 4'($urandom);
         tlast  = (i == tlast_at);
         exp_data = tdata & data_mask();
         #1;
         w = 0;
         while (!o_tready && w < 50) begin @(negedge clk); w++; end
         if (!o_tready) begin
            n_cmp++; n_bad++;
            $display("FAIL %s_tready_wait beat %0d: got 0 want 1", tag, i);
            tvalid = 1'b0; tlast = 1'b0;
            return;
         end
         @(posedge clk); #1;
         n_cmp++;
         if (o_shift !== 1'b1 || o_data !== exp_data) begin
            n_bad++;
            $display("FAIL %s_shift beat %0d: got shift=%0b data=%0h want shift=1 data=%0h",
                     tag, i, o_shift, o_data, exp_data);
         end
         n_cmp++;
         if (o_run_en !== 1'b0) begin
            n_bad++; $display("FAIL %s_run_en_load beat %0d: got %0b want 0", tag, i, o_run_en);
         end
         @(negedge clk);
      end
      tvalid = 1'b0;
      tlast  = 1'b0;
      if (check_end) begin
         ok = stream_ok(total_beats(), tlast_at);
         @(negedge clk);
         n_cmp++;
         if (shift_seen - start !== n) begin
            n_bad++; $display("FAIL %s_shift_count: got %0d want %0d", tag, shift_seen - start, n);
         end
         n_cmp++;
         if (o_ready !== ok || o_error !== !ok) begin
            n_bad++; $display("FAIL %s_status: got ready=%0b error=%0b want ready=%0b error=%0b",
                              tag, o_ready, o_error, ok, !ok);
         end
         n_cmp++;
         if (o_tready !== 1'b0) begin
            n_bad++; $display("FAIL %s_tready_after: got %0b want 0", tag, o_tready);
         end
         n_cmp++;
         if (o_run_en !== (ok && run)) begin
            n_bad++; $display("FAIL %s_run_en_after: got %0b want %0b", tag, o_run_en, ok && run);
         end
      end
      $display("stream %s: %0d beats driven, tlast_at=%0d", tag, n, tlast_at);
   endtask

   task automatic test_reset();
      #12;
      for (int s = 0; s < 2; s++) begin
         sel = s;
         #1;
         n_cmp++;
         if ({o_tready, o_ready, o_error, o_shift, o_run_en, o_data} !== 9'b0) begin
            n_bad++; $display("FAIL reset_outputs dut%0d: got %0h want 0", s,
                              {o_tready, o_ready, o_error, o_shift, o_run_en, o_data});
         end
      end
      sel = 0;
      @(negedge clk); rst_n = 1'b1;
      tvalid = 1'b1;
      @(negedge clk); @(negedge clk);
      n_cmp++;
      if (o_tready !== 1'b0 || o_ready !== 1'b0) begin
         n_bad++; $display("FAIL reset_idle: got tready=%0b ready=%0b want 0 0", o_tready, o_ready);
      end
      tvalid = 1'b0;
   endtask

   task automatic test_back_to_back();
      sel = 0;
      run = 1'b1;
      pulse_cfg();
      send_stream(total_beats(), total_beats() - 1, 0, 1'b1, "b2b");
   endtask

   task automatic test_gaps();
      sel = 0;
      tvalid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_cmp++;
         if (o_tready !== 1'b0 || o_shift !== 1'b0) begin
            n_bad++; $display("FAIL ready_stalls: got tready=%0b shift=%0b want 0 0", o_tready, o_shift);
         end
      end
      tvalid = 1'b0;
      pulse_cfg();
      send_stream(total_beats(), total_beats() - 1, 5, 1'b1, "gaps");
   endtask

   task automatic test_early_tlast();
      sel = 0;
      pulse_cfg();
      send_stream(beats_accepted(total_beats(), 40), 40, 2, 1'b1, "early");
      tvalid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         n_cmp++;
         if (o_tready !== 1'b0 || o_shift !== 1'b0 || o_error !== 1'b1) begin
            n_bad++; $display("FAIL error_hold: got tready=%0b shift=%0b error=%0b want 0 0 1",
                              o_tready, o_shift, o_error);
         end
      end
      tvalid = 1'b0;
      pulse_cfg();
      send_stream(total_beats(), total_beats() - 1, 1, 1'b1, "recover");
   endtask

   task automatic test_missing_tlast();
      sel = 0;
      pulse_cfg();
      send_stream(beats_accepted(total_beats(), -1), -1, 1, 1'b1, "notlast");
   endtask

   task automatic test_timeout();
      sel = 0;
      pulse_cfg();
      send_stream(11, -1, 0, 1'b0, "stall");
      for (int c = 0; c <= 16; c++) begin
         n_cmp++;
         if (o_error !== (c == 16)) begin
            n_bad++; $display("FAIL timeout cycle %0d: got error=%0b want %0b", c, o_error, c == 16);
         end
         if (c < 16) @(negedge clk);
      end
      n_cmp++;
      if (o_tready !== 1'b0) begin
         n_bad++; $display("FAIL timeout_tready: got %0b want 0", o_tready);
      end
   endtask

   task automatic test_width4();
      sel = 1;
      pulse_cfg();
      send_stream(total_beats(), total_beats() - 1, 2, 1'b1, "w4");
      pulse_cfg();
      send_stream(20, -1, 1, 1'b0, "w4_part");
      tvalid = 1'b1;
      tdata  = 4'($urandom);
      cfg    = 1'b1;
      #1;
      n_cmp++;
      if (o_tready !== 1'b0) begin
         n_bad++; $display("FAIL cfg_vs_beat_tready: got %0b want 0", o_tready);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (o_shift !== 1'b0) begin
         n_bad++; $display("FAIL cfg_vs_beat_shift: got %0b want 0", o_shift);
      end
      @(negedge clk);
      cfg = 1'b0;
      tvalid = 1'b0;
      send_stream(total_beats(), total_beats() - 1, 1, 1'b1, "w4_restart");
   endtask

   task automatic test_reset_mid_load();
      sel = 0;
      pulse_cfg();
      send_stream(30, -1, 0, 1'b0, "pre_rst");
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({o_tready, o_ready, o_error, o_shift, o_run_en, o_data} !== 9'b0) begin
         n_bad++; $display("FAIL async_reset: got %0h want 0",
                           {o_tready, o_ready, o_error, o_shift, o_run_en, o_data});
      end
      @(negedge clk); rst_n = 1'b1;
      tvalid = 1'b1;
      @(negedge clk); @(negedge clk);
      n_cmp++;
      if (o_tready !== 1'b0 || o_ready !== 1'b0 || o_error !== 1'b0 || o_run_en !== 1'b0) begin
         n_bad++; $display("FAIL post_reset_idle: got tready=%0b ready=%0b error=%0b run_en=%0b want 0",
                           o_tready, o_ready, o_error, o_run_en);
      end
      tvalid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_gaps();
      test_early_tlast();
      test_missing_tlast();
      test_timeout();
      test_width4();
      test_reset_mid_load();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

endmodule
